// File: rtl/fetch_unit_if.sv
// Decode-side handshake of the fetch unit: head entry presented with a
// valid/ready pair. The fetch unit is the master, decode is the slave.
interface fetch_unit_if;
  logic        fetch_valid_output;
  logic [31:0] fetch_instruction_output;
  logic [63:0] fetch_pc_output;
  logic        decode_ready_input;

  modport master (
    output fetch_valid_output,
    output fetch_instruction_output,
    output fetch_pc_output,
    input  decode_ready_input
  );

  modport slave (
    input  fetch_valid_output,
    input  fetch_instruction_output,
    input  fetch_pc_output,
    output decode_ready_input
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// queues {PC, instruction} pairs for decode. Taken branches redirect the PC
// and squash every queued (younger) entry.
// Optional build macro FETCH_PERF_COUNTERS_EN adds the fetched/stall
// performance counters; without it both counter outputs read zero.
module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] rom_address_output,
  input  logic [31:0] rom_instruction_input,
  input  logic        stall_input,
  input  logic        branch_taken_input,
  input  logic [63:0] branch_target_input,
  fetch_unit_if.master dec,
  output logic        misaligned_flag_output,
  output logic [31:0] fetched_count_output,
  output logic [31:0] stall_count_output
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(QUEUE_DEPTH);

  logic [63:0]   r_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_misaligned;

  // Queue storage carries no reset; the occupancy counter qualifies it.
  logic [63:0]   r_q_pc    [QUEUE_DEPTH];
  logic [31:0]   r_q_instr [QUEUE_DEPTH];

  logic w_empty;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;

  // Handshake qualification; a redirect squashes the head and blocks the push.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == LP_DEPTH);
    w_valid = !w_empty && !branch_taken_input;
    w_pop   = w_valid && dec.decode_ready_input;
    w_push  = !reset && !branch_taken_input && !stall_input && (!w_full || w_pop);
  end

  // PC, queue pointers, occupancy and sticky misalignment flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
    end else if (branch_taken_input) begin
      r_pc    <= {branch_target_input[63:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      if (branch_target_input[1:0] != 2'b00) begin
        r_misaligned <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 64'd4;
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the ROM word alongside the PC that addressed it.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_pc;
      r_q_instr[r_tail] <= rom_instruction_input;
    end
  end

  assign rom_address_output           = r_pc;
  assign dec.fetch_valid_output       = w_valid;
  assign dec.fetch_instruction_output = r_q_instr[r_head];
  assign dec.fetch_pc_output          = r_q_pc[r_head];
  assign misaligned_flag_output       = r_misaligned;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_fetched_cnt;
  logic [31:0] r_stall_cnt;

  // Performance counters: pushes, and idle cycles that were not redirects.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetched_cnt <= 32'h0;
      r_stall_cnt   <= 32'h0;
    end else begin
      if (w_push) begin
        r_fetched_cnt <= r_fetched_cnt + 32'd1;
      end
      if (!w_push && !branch_taken_input) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetched_count_output = r_fetched_cnt;
  assign stall_count_output   = r_stall_cnt;
`else
  assign fetched_count_output = 32'h0;
  assign stall_count_output   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected decode-visible PCs are queued by
// the stimulus, and a monitor pops and compares on every accepted head entry.
module tb_fetch_unit;

`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_input = 1'b0;
  logic        branch_taken_input = 1'b0;
  logic [63:0] branch_target_input = 64'h0;
  logic [63:0] rom_address_output;
  logic [31:0] rom_instruction_input;
  logic        misaligned_flag_output;
  logic [31:0] fetched_count_output;
  logic [31:0] stall_count_output;

  fetch_unit_if dif ();

  fetch_unit #(.RESET_PC(64'h0), .QUEUE_DEPTH(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .rom_address_output    (rom_address_output),
    .rom_instruction_input (rom_instruction_input),
    .stall_input           (stall_input),
    .branch_taken_input    (branch_taken_input),
    .branch_target_input   (branch_target_input),
    .dec                   (dif),
    .misaligned_flag_output(misaligned_flag_output),
    .fetched_count_output  (fetched_count_output),
    .stall_count_output    (stall_count_output)
  );

  always #5 clock = ~clock;

  // Address-tagged ROM contents
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign rom_instruction_input = rom_word(rom_address_output);

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_pc[$];
  logic [63:0] m_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic mid;
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset;
    dif.decode_ready_input = 1'b0;
    stall_input            = 1'b0;
    branch_taken_input     = 1'b0;
    reset                  = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Monitor: every accepted head entry must match the next expected PC
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && dif.fetch_valid_output === 1'b1 && dif.decode_ready_input === 1'b1) begin
        if (sb_pc.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %0h, expected no valid entry", dif.fetch_pc_output);
        end else begin
          m_exp = sb_pc.pop_front();
          chk("pop_pc", dif.fetch_pc_output, m_exp);
          chk("pop_instr", {32'h0, dif.fetch_instruction_output}, {32'h0, rom_word(m_exp)});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and streaming with decode always ready
    do_reset();
    dif.decode_ready_input = 1'b1;
    mid();
    chk("reset_pc", rom_address_output, 64'h0);
    chk("reset_valid", {63'h0, dif.fetch_valid_output}, 64'h0);
    chk("reset_flag", {63'h0, misaligned_flag_output}, 64'h0);
    chk("reset_fetched", {32'h0, fetched_count_output}, 64'h0);
    chk("reset_stallcnt", {32'h0, stall_count_output}, 64'h0);
    sb_pc.push_back(64'h0);
    sb_pc.push_back(64'h4);
    sb_pc.push_back(64'h8);
    sb_pc.push_back(64'hC);
    tick(4);
    mid();
    chk("stream_drained", 64'(sb_pc.size()), 64'h0);

    // Decode not ready: fill, hold PC at 16, then drain without gap
    do_reset();
    tick(7);
    mid();
    chk("full_pc_hold", rom_address_output, 64'h10);
    chk("full_valid", {63'h0, dif.fetch_valid_output}, 64'h1);
    chk("full_stallcnt", {32'h0, stall_count_output}, PERF ? 64'd3 : 64'd0);
    chk("full_fetched", {32'h0, fetched_count_output}, PERF ? 64'd4 : 64'd0);
    sb_pc.push_back(64'h0);
    sb_pc.push_back(64'h4);
    sb_pc.push_back(64'h8);
    sb_pc.push_back(64'hC);
    sb_pc.push_back(64'h10);
    tick(1);
    dif.decode_ready_input = 1'b1;
    tick(5);
    dif.decode_ready_input = 1'b0;
    mid();
    chk("drain_done", 64'(sb_pc.size()), 64'h0);

    // Redirect to 0x100 with three entries queued
    do_reset();
    tick(3);
    branch_taken_input     = 1'b1;
    branch_target_input    = 64'h100;
    dif.decode_ready_input = 1'b1;
    mid();
    chk("redir_valid_n", {63'h0, dif.fetch_valid_output}, 64'h0);
    tick(1);
    branch_taken_input = 1'b0;
    mid();
    chk("redir_valid_n1", {63'h0, dif.fetch_valid_output}, 64'h0);
    chk("redir_pc", rom_address_output, 64'h100);
    sb_pc.push_back(64'h100);
    sb_pc.push_back(64'h104);
    tick(3);
    dif.decode_ready_input = 1'b0;
    mid();
    chk("redir_drained", 64'(sb_pc.size()), 64'h0);

    // Misaligned redirect target sets a sticky flag
    chk("flag_before", {63'h0, misaligned_flag_output}, 64'h0);
    tick(1);
    branch_taken_input  = 1'b1;
    branch_target_input = 64'h102;
    tick(1);
    branch_taken_input = 1'b0;
    mid();
    chk("misalign_pc", rom_address_output, 64'h100);
    chk("misalign_flag", {63'h0, misaligned_flag_output}, 64'h1);
    tick(1);
    branch_taken_input  = 1'b1;
    branch_target_input = 64'h200;
    tick(1);
    branch_taken_input = 1'b0;
    tick(3);
    mid();
    chk("flag_sticky", {63'h0, misaligned_flag_output}, 64'h1);
    chk("aligned_pc", rom_address_output, 64'h20C);

    // Stall for three cycles: queue drains, PC holds
    do_reset();
    tick(2);
    stall_input            = 1'b1;
    dif.decode_ready_input = 1'b1;
    sb_pc.push_back(64'h0);
    sb_pc.push_back(64'h4);
    tick(3);
    stall_input            = 1'b0;
    dif.decode_ready_input = 1'b0;
    mid();
    chk("stall_pc_hold", rom_address_output, 64'h8);
    chk("stall_drained", {63'h0, dif.fetch_valid_output}, 64'h0);
    chk("stall_cnt", {32'h0, stall_count_output}, PERF ? 64'd3 : 64'd0);
    chk("stall_fetched", {32'h0, fetched_count_output}, PERF ? 64'd2 : 64'd0);
    chk("stall_sb", 64'(sb_pc.size()), 64'h0);
    tick(1);
    dif.decode_ready_input = 1'b1;
    sb_pc.push_back(64'h8);
    tick(1);
    dif.decode_ready_input = 1'b0;
    mid();
    chk("resume_sb", 64'(sb_pc.size()), 64'h0);

    // Reset with a full queue, flag set and redirect pending
    do_reset();
    tick(4);
    branch_taken_input  = 1'b1;
    branch_target_input = 64'h102;
    tick(1);
    branch_taken_input = 1'b0;
    tick(4);
    mid();
    chk("pre_flag", {63'h0, misaligned_flag_output}, 64'h1);
    chk("pre_valid", {63'h0, dif.fetch_valid_output}, 64'h1);
    chk("pre_pc", rom_address_output, 64'h110);
    chk("pre_fetched", {32'h0, fetched_count_output}, PERF ? 64'd8 : 64'd0);
    tick(1);
    reset                  = 1'b1;
    branch_taken_input     = 1'b1;
    branch_target_input    = 64'h300;
    dif.decode_ready_input = 1'b1;
    tick(1);
    reset                  = 1'b0;
    branch_taken_input     = 1'b0;
    dif.decode_ready_input = 1'b0;
    mid();
    chk("rst_pc", rom_address_output, 64'h0);
    chk("rst_valid", {63'h0, dif.fetch_valid_output}, 64'h0);
    chk("rst_flag", {63'h0, misaligned_flag_output}, 64'h0);
    chk("rst_fetched", {32'h0, fetched_count_output}, 64'h0);
    chk("rst_stallcnt", {32'h0, stall_count_output}, 64'h0);
    chk("final_sb", 64'(sb_pc.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction ROM. It owns the program counter and drives the ROM's byte address, then captures the returned 32-bit instruction together with its PC into a small FIFO queue. The queue feeds the decode stage through a valid/ready handshake. Taken branches from the execute stage redirect the PC and squash all queued (younger) instructions.

## Interface
- RESET_PC, 64'h0: PC value loaded on reset; must be 4-byte aligned.
- QUEUE_DEPTH, 4: fetch queue entries; power of two, range 2..16.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rom_address_output  output  64  byte address to ROM; equals the current PC register.
- rom_instruction_input  input  32  instruction returned combinationally by ROM for rom_address_output.
- stall_input  input  1  suppresses fetch (no push, PC holds).
- branch_taken_input  input  1  redirect request from execute.
- branch_target_input  input  64  redirect byte address.
- decode_ready_input  input  1  decode accepts head entry this cycle.
- fetch_valid_output  output  1  head entry valid.
- fetch_instruction_output  output  32  head instruction.
- fetch_pc_output  output  64  PC of head instruction.
- misaligned_flag_output  output  1  sticky; set when a redirect target has bits[1:0] != 0.
- fetched_count_output  output  32  instructions pushed (see Configuration).
- stall_count_output  output  32  cycles with no push and no redirect (see Configuration).

## Operation
- The PC register drives rom_address_output directly. ROM data is sampled in the same cycle.
- Push condition: !reset && !branch_taken_input && !stall_input && (queue not full || pop this cycle).
- On push: write {PC, rom_instruction_input} at the tail; PC <= PC + 4 (64-bit modulo wrap).
- Pop condition: fetch_valid_output && decode_ready_input; the head advances.
- Redirect (branch_taken_input=1) has the highest priority after reset:
  - The queue is cleared.
  - PC <= {branch_target_input[63:2], 2'b00}.
  - No push occurs that cycle.
  - If branch_target_input[1:0] != 0, misaligned_flag_output is set and held until reset.
- fetch_valid_output = queue non-empty && !branch_taken_input. This squashes a head that is younger than the branch. A redirect cycle therefore never counts as a pop.
- stall_input only gates pushes. Pops continue while stalled.
- Full queue with decode_ready_input=1: push and pop occur in the same cycle, occupancy is unchanged, and the PC advances.
- Empty queue: fetch_valid_output=0, and the outputs show the slot at the head pointer (don't-care).
- Occupancy counter width: log2(QUEUE_DEPTH)+1. Head and tail pointers wrap modulo QUEUE_DEPTH.

## Timing
- Reset values:
  - PC = RESET_PC.
  - Queue empty; fetch_valid_output = 0.
  - misaligned_flag_output = 0.
  - Both counters = 0.
- Latency: an instruction pushed at edge N is presented on fetch_*_output after edge N, i.e. 1 cycle from address to decode visibility.
- Redirect asserted in cycle N: from edge N, PC = target. The target instruction is pushed at edge N+1 and becomes valid in cycle N+2 (2-cycle branch bubble).
- Reset asserted mid-operation overrides redirect, stall and handshakes. The state is reinitialised at that edge.
- Steady state with no stalls and decode always ready: 1 instruction per cycle.

## Configuration
- FETCH_PERF_COUNTERS_EN defined:
  - fetched_count_output increments on every push.
  - stall_count_output increments in every non-reset cycle with no push and no redirect.
  - Both wrap at 2^32.
- FETCH_PERF_COUNTERS_EN undefined: the counter registers are not built and both outputs are tied to 32'h0.

## Test plan
- Reset with RESET_PC=0; ROM returns address-tagged words; decode_ready_input=1. Expect fetch_pc_output = 0, 4, 8, 12 on consecutive cycles starting one cycle after reset release, with matching instructions.
- Hold decode_ready_input=0 with QUEUE_DEPTH=4:
  - PC stops at 16 once 4 entries are queued; stall_count increments.
  - Release ready: PCs 0..12 drain in order, then 16 follows with no gap.
- Redirect to 0x100 while the queue holds 3 entries:
  - fetch_valid_output=0 in the redirect cycle and the next cycle.
  - The next valid PC is 0x100, with 0 pops during the redirect cycle.
- Redirect to 0x102: PC becomes 0x100, misaligned_flag_output=1 and it stays set until reset.
- stall_input high for 3 cycles with a non-empty queue and ready=1:
  - The queue drains and the PC holds.
  - With FETCH_PERF_COUNTERS_EN, stall_count_output increases by 3.
- Assert reset while the queue is full and a redirect is pending: the next cycle shows PC=RESET_PC, valid=0, flag=0 and counters=0.
